// File: rtl/lcd_message_streamer.sv
// lcd_message_streamer
//   Streams one of NUM_MSGS fixed character strings to the LCD driver over a
//   valid/ready handshake. A programmable idle wait follows every accepted
//   character, and repeat mode replays the message until it is aborted.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous active-low reset
//   iStart   in   start request, sampled only while idle
//   iMsgSel  in   message select, latched on an accepted start
//   iRepeat  in   loop the message until aborted, latched on an accepted start
//   iAbort   in   synchronous stop from any busy state
//   iReady   in   LCD driver accepts oChar this cycle
//   oChar    out  current character (registered)
//   oValid   out  oChar valid
//   oBusy    out  high in every state except idle
//   oDone    out  one-cycle pulse at the end of each message pass
//   oIndex   out  characters accepted in the current pass
module lcd_message_streamer #(
  parameter int CHAR_W       = 8,
  parameter int NUM_MSGS     = 4,
  parameter int SEL_W        = 2,
  parameter int MSG_LEN      = 16,
  parameter int IDX_W        = 5,
  parameter int DELAY_W      = 16,
  parameter int DELAY_CYCLES = 1005
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [SEL_W-1:0]  iMsgSel,
  input  logic              iRepeat,
  input  logic              iAbort,
  input  logic              iReady,
  output logic [CHAR_W-1:0] oChar,
  output logic              oValid,
  output logic              oBusy,
  output logic              oDone,
  output logic [IDX_W-1:0]  oIndex
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  // Message table: each entry is left-justified and NUL padded, so the
  // first character sits in the top byte.
  localparam int unsigned TBL_MSGS = 4;
  localparam int unsigned TBL_LEN  = 16;
  localparam logic [8*TBL_LEN-1:0] MSG_TBL [TBL_MSGS] = '{
    {"HolaMundo", 56'h0},
    128'h0,
    "0123456789ABCDEF",
    {"E2", 112'h0}
  };

  // Selects outside the table, or indices past either length limit, read NUL.
  function automatic logic [CHAR_W-1:0] rom_read(input logic [SEL_W-1:0] s,
                                                 input logic [IDX_W-1:0] i);
    logic [7:0]  ch;
    int unsigned pos;
    ch  = '0;
    pos = 0;
    for (int unsigned m = 0; m < TBL_MSGS; m++) begin
      if (m < NUM_MSGS && 32'(s) == m && 32'(i) < TBL_LEN && 32'(i) < MSG_LEN) begin
        pos = 8 * (TBL_LEN - 1 - 32'(i));
        ch  = MSG_TBL[m[1:0]][pos +: 8];
      end
    end
    return CHAR_W'(ch);
  endfunction

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               rpt_q, rpt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [CHAR_W-1:0]  char_q, char_d;
  logic [CHAR_W-1:0]  rom_ch;

  assign rom_ch = rom_read(sel_q, idx_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rpt_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rpt_q   <= rpt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    char_d  = char_q;

    case (state_q)
      S_IDLE: begin
        if (iStart && !iAbort) begin
          sel_d   = iMsgSel;
          rpt_d   = iRepeat;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The length limit is tested before the table is consulted, so a
        // full-length message never reads a character past its end.
        if (idx_q == IDX_W'(MSG_LEN)) begin
          state_d = S_DONE;
        end else begin
          char_d  = rom_ch;
          state_d = (rom_ch == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (iReady) begin
          idx_d = idx_q + IDX_W'(1);
          if (DELAY_CYCLES > 0) begin
            cnt_d   = DELAY_W'(DELAY_CYCLES - 1);
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - DELAY_W'(1);
      end
      S_DONE: begin
        if (rpt_q) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition; a handshake in the same SEND cycle
    // still counts, otherwise the index is left untouched.
    if (iAbort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      if (state_q != S_SEND) idx_d = idx_q;
    end
  end

  assign oChar  = char_q;
  assign oValid = (state_q == S_SEND);
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = (state_q == S_DONE);
  assign oIndex = idx_q;

endmodule
